// File: rtl/wb_register_file.sv
// ---------------------------------------------------------------------------
// wb_register_file
//   Write-back stage plus general-purpose register file, with a debug
//   channel that streams every register out over a valid/ready handshake
//   while the pipeline is halted.
//
// Ports
//   clock_i, reset_i            : clock, asynchronous active-high reset
//   enable_pipe_i               : pipeline enable (low = halted)
//   reg_write_i, write_register_i, mem_to_reg_i
//                               : write-back control from MEM/WB
//   mem_data_read_i, alu_result_i, pc_i
//                               : write-back data candidates
//   read_reg_a_i/b_i            : decode-stage read addresses
//   read_data_a_o/b_o           : decode-stage read data (combinational)
//   wb_data_o                   : selected write-back value (forwarding)
//   dump_start_i, dbg_ready_i   : debug dump request / sink ready
//   dbg_valid_o, dbg_index_o, dbg_data_o, dbg_busy_o, dbg_done_o
//                               : debug dump beat and status
// ---------------------------------------------------------------------------
module wb_register_file #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_PC   = 7
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_pipe_i,
  input  logic               reg_write_i,
  input  logic [NB_REG-1:0]  write_register_i,
  input  logic [1:0]         mem_to_reg_i,
  input  logic [NB_DATA-1:0] mem_data_read_i,
  input  logic [NB_DATA-1:0] alu_result_i,
  input  logic [NB_PC-1:0]   pc_i,
  input  logic [NB_REG-1:0]  read_reg_a_i,
  input  logic [NB_REG-1:0]  read_reg_b_i,
  output logic [NB_DATA-1:0] read_data_a_o,
  output logic [NB_DATA-1:0] read_data_b_o,
  output logic [NB_DATA-1:0] wb_data_o,
  input  logic               dump_start_i,
  input  logic               dbg_ready_i,
  output logic               dbg_valid_o,
  output logic [NB_REG-1:0]  dbg_index_o,
  output logic [NB_DATA-1:0] dbg_data_o,
  output logic               dbg_busy_o,
  output logic               dbg_done_o
);

  localparam int NUM_REGS = 1 << NB_REG;
  localparam logic [NB_REG-1:0]  ZERO_IDX  = {NB_REG{1'b0}};
  localparam logic [NB_REG-1:0]  ONE_IDX   = {{(NB_REG-1){1'b0}}, 1'b1};
  localparam logic [NB_REG-1:0]  LAST_IDX  = {NB_REG{1'b1}};
  localparam logic [NB_DATA-1:0] ZERO_DATA = {NB_DATA{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } dump_state_t;

  logic [NB_DATA-1:0] regs_q [NUM_REGS];
  logic [NB_DATA-1:0] wb_data_s;
  logic               we_s;

  dump_state_t        state_q, state_d;
  logic [NB_REG-1:0]  index_q, index_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [NB_REG-1:0]  dump_addr_s;
  logic [NB_DATA-1:0] dump_data_s;

  // Register 0 is hard-wired to zero; a same-cycle write is forwarded.
  function automatic logic [NB_DATA-1:0] bypass_read(
    input logic [NB_REG-1:0]  addr,
    input logic [NB_DATA-1:0] stored,
    input logic               we,
    input logic [NB_REG-1:0]  waddr,
    input logic [NB_DATA-1:0] wdata
  );
    logic [NB_DATA-1:0] r;
    if (addr == ZERO_IDX) begin
      r = ZERO_DATA;
    end else if (we && (addr == waddr)) begin
      r = wdata;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  // Write-back source select.
  always_comb begin
    wb_data_s = alu_result_i;
    case (mem_to_reg_i)
      2'b00:   wb_data_s = alu_result_i;
      2'b01:   wb_data_s = mem_data_read_i;
      2'b10:   wb_data_s = {{(NB_DATA-NB_PC){1'b0}}, pc_i};
      2'b11:   wb_data_s = alu_result_i;
      default: wb_data_s = alu_result_i;
    endcase
  end

  assign wb_data_o = wb_data_s;
  assign we_s      = reg_write_i && enable_pipe_i && (write_register_i != ZERO_IDX);

  assign read_data_a_o = bypass_read(read_reg_a_i, regs_q[read_reg_a_i], we_s, write_register_i, wb_data_s);
  assign read_data_b_o = bypass_read(read_reg_b_i, regs_q[read_reg_b_i], we_s, write_register_i, wb_data_s);

  // Register array storage; entry 0 is never written.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= ZERO_DATA;
      end
    end else if (we_s) begin
      regs_q[write_register_i] <= wb_data_s;
    end
  end

  // Index of the beat the dump will present next: 0 when starting, else index+1.
  always_comb begin
    dump_addr_s = index_q + ONE_IDX;
    if (state_q == ST_IDLE) begin
      dump_addr_s = ZERO_IDX;
    end else begin
      dump_addr_s = index_q + ONE_IDX;
    end
  end

  // Beat data is captured when the index advances, so a later write to the
  // presented register cannot disturb the beat in flight.
  assign dump_data_s = bypass_read(dump_addr_s, regs_q[dump_addr_s], we_s, write_register_i, wb_data_s);

  // Dump FSM next-state and registered-output next values.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dump_start_i && !enable_pipe_i) begin
          state_d = ST_SEND;
          index_d = ZERO_IDX;
          data_d  = dump_data_s;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND, ST_WAIT: begin
        if (dbg_ready_i) begin
          if (index_q == LAST_IDX) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SEND;
            index_d = dump_addr_s;
            data_d  = dump_data_s;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        index_d = ZERO_IDX;
        data_d  = ZERO_DATA;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        index_d = ZERO_IDX;
        data_d  = ZERO_DATA;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Dump FSM state and debug output registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      index_q <= ZERO_IDX;
      data_q  <= ZERO_DATA;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dbg_valid_o = valid_q;
  assign dbg_index_o = index_q;
  assign dbg_data_o  = data_q;
  assign dbg_busy_o  = busy_q;
  assign dbg_done_o  = done_q;

endmodule

// File: doc/wb_register_file.md
WB_REGISTER_FILE -- requirements
Module: wb_register_file

Interface
Parameters:
REQ-001 The block SHALL have parameter NB_DATA, default 32, data word width.
REQ-002 The block SHALL have parameter NB_REG, default 5, register address width (2^NB_REG registers).
REQ-003 The block SHALL have parameter NB_PC, default 7, width of the return PC from write-back.

Ports:
REQ-004 The block SHALL have port clock_i  in  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset_i  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port enable_pipe_i  in  1  pipeline enable; low means the pipeline is halted.
REQ-007 The block SHALL have ports reg_write_i  in  1, write_register_i  in  NB_REG, mem_to_reg_i  in  2: write-back control from MEM/WB.
REQ-008 The block SHALL have ports mem_data_read_i  in  NB_DATA, alu_result_i  in  NB_DATA, pc_i  in  NB_PC: write-back data candidates.
REQ-009 The block SHALL have ports read_reg_a_i, read_reg_b_i  in  NB_REG, and read_data_a_o, read_data_b_o  out  NB_DATA: decode-stage read ports.
REQ-010 The block SHALL have ports wb_data_o  out  NB_DATA: selected write-back value, for forwarding.
REQ-011 The block SHALL have ports dump_start_i  in  1, dbg_ready_i  in  1, dbg_valid_o  out  1, dbg_index_o  out  NB_REG, dbg_data_o  out  NB_DATA, dbg_busy_o  out  1, dbg_done_o  out  1: debug dump channel.

Function
REQ-012 wb_data_o SHALL be combinational: mem_to_reg_i 00 -> alu_result_i, 01 -> mem_data_read_i, 10 -> pc_i zero-extended to NB_DATA, 11 -> alu_result_i.
REQ-013 On a rising edge with reg_write_i=1, enable_pipe_i=1 and write_register_i!=0, register[write_register_i] SHALL take wb_data_o.
REQ-014 Register 0 SHALL read 0 at all times; writes to it SHALL be discarded.
REQ-015 Read ports SHALL be combinational, zero-latency.
REQ-016 Write-through bypass: if reg_write_i=1, enable_pipe_i=1, write_register_i!=0 and equals a read address, that port SHALL return wb_data_o in the same cycle.
REQ-017 Both read ports addressing the same register SHALL return identical data.
REQ-018 Dump FSM states: IDLE, SEND, WAIT, DONE.
REQ-019 IDLE -> SEND when dump_start_i=1 and enable_pipe_i=0; dump_start_i SHALL be ignored while enable_pipe_i=1 or FSM not IDLE.
REQ-020 On entering SEND, index counter SHALL be 0; in SEND, dbg_valid_o=1, dbg_index_o=index, dbg_data_o=register[index] (0 for index 0).
REQ-021 SEND with dbg_ready_i=1 SHALL complete the transfer that cycle: index<last -> index+1, stay SEND; index=last (2^NB_REG-1) -> DONE. SEND with dbg_ready_i=0 -> WAIT.
REQ-022 WAIT SHALL hold dbg_valid_o=1, index and data stable until dbg_ready_i=1, then behave as a completed SEND transfer.
REQ-023 DONE SHALL assert dbg_done_o for exactly one cycle, then return to IDLE; index SHALL not wrap past last.
REQ-024 dbg_busy_o SHALL be 1 in SEND, WAIT and DONE, else 0.
REQ-025 If enable_pipe_i rises mid-dump, the dump SHALL continue; register writes enabled by REQ-013 SHALL take effect, and a write to the currently presented index SHALL not change dbg_data_o until the next index.

Reset
REQ-026 reset_i=1 SHALL immediately, without clock, clear all registers to 0, force FSM to IDLE, index to 0, dbg_valid_o, dbg_busy_o, dbg_done_o, dbg_data_o, dbg_index_o to 0.
REQ-027 Reset mid-dump SHALL abort without dbg_done_o; after release a new dump_start_i SHALL restart at index 0.

Verification
REQ-028 Write r5 with alu_result_i=0x1234, mem_to_reg_i=00 -> next cycle read_data_a_o(r5)=0x00001234; same cycle bypass read also 0x1234.
REQ-029 Write r0 with 0xFFFFFFFF -> read r0 = 0; mem_to_reg_i=10, pc_i=7'h45, write r31 -> r31=0x00000045.
REQ-030 enable_pipe_i=0, reg_write_i=1 -> no register change; dump_start_i with enable_pipe_i=1 -> dbg_busy_o stays 0.
REQ-031 Load rN=N*0x11, halt, dump with dbg_ready_i=1 -> 32 consecutive valid beats, index 0..31, data N*0x11, one-cycle dbg_done_o after beat 31.
REQ-032 Dump with dbg_ready_i toggled randomly -> no beat lost or duplicated, data stable while waiting; async reset at index 10 -> outputs 0 at once, no dbg_done_o, registers all 0.
